// File: rtl/and16_bist.sv
// and16_bist: walking-ones stimulus/check engine for a 16-bit AND datapath.
// Optional: define BIST_STOP_ON_FAIL_EN to end the run at the first mismatch.
module and16_bist #(
    parameter int SETTLE = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic [15:0] a,
    output logic [15:0] b,
    input  logic [15:0] out_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [8:0]  err_count,
    output logic [3:0]  fail_i,
    output logic [3:0]  fail_j
);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        WAIT,
        CHECK,
        FIN
    } state_t;

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

    state_t        state;
    logic [3:0]    i;
    logic [3:0]    j;
    logic [CW-1:0] cnt;

    logic          mism;
    logic          last;
    logic [3:0]    ni;
    logic [3:0]    nj;

    // ones in bits [n:0]
    function automatic logic [15:0] ones(input logic [3:0] n);
        return 16'hFFFF >> (4'd15 - n);
    endfunction

    // compare the registered operands, never next-state values
    assign mism = (out_in != (a & b));
    assign last = (i == 4'hF) && (j == 4'hF);
    assign nj   = j + 4'd1;
    assign ni   = (j == 4'hF) ? i + 4'd1 : i;

    // sequencer: vector walk, settle wait, check and result latching
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            i         <= '0;
            j         <= '0;
            cnt       <= '0;
            a         <= '0;
            b         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_i    <= '0;
            fail_j    <= '0;
        end else begin
            unique case (state)
                IDLE, FIN: begin
                    if (start) begin
                        state     <= APPLY;
                        i         <= '0;
                        j         <= '0;
                        a         <= ones(4'd0);
                        b         <= ones(4'd0);
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= '0;
                        fail_i    <= '0;
                        fail_j    <= '0;
                    end
                end
                APPLY: begin
                    state <= WAIT;
                    cnt   <= '0;
                end
                WAIT: begin
                    if (cnt == LAST) begin
                        state <= CHECK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (mism) begin
                        err_count <= err_count + 9'd1;
                        if (err_count == 9'd0) begin
                            fail_i <= i;
                            fail_j <= j;
                        end
                    end
`ifdef BIST_STOP_ON_FAIL_EN
                    if (last || mism) begin
`else
                    if (last) begin
`endif
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == 9'd0) && !mism;
                    end else begin
                        state <= APPLY;
                        i     <= ni;
                        j     <= nj;
                        a     <= ones(ni);
                        b     <= ones(nj);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_and16_bist.sv
// tb_and16_bist: directed checks of and16_bist against a behavioural AND array.
// Faulty-array modes: bit-5 stuck-at-0 and output tied high.
module tb_and16_bist;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out_in;
    logic        busy;
    logic        done;
    logic        pass;
    logic [8:0]  err_count;
    logic [3:0]  fail_i;
    logic [3:0]  fail_j;

    int mode;
    int n_checks;
    int n_fail;
    int cyc;

    and16_bist #(.SETTLE(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .out_in    (out_in),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_i    (fail_i),
        .fail_j    (fail_j)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // model of the AND array, optionally faulty
    always_comb begin
        out_in = a & b;
        if (mode == 1) out_in = (a & b) & ~16'h0020;
        if (mode == 2) out_in = 16'hFFFF;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a"}, 32'(a), 32'h0);
        chk({tag, "_b"}, 32'(b), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_pass"}, 32'(pass), 32'h0);
        chk({tag, "_err"}, 32'(err_count), 32'h0);
        chk({tag, "_fi"}, 32'(fail_i), 32'h0);
        chk({tag, "_fj"}, 32'(fail_j), 32'h0);
    endtask

    // start a run; count clocks from the sampling edge until done
    task automatic run(input int repulse, input int rst_at,
                       output int n);
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        chk("run_busy0", 32'(busy), 32'h1);
        chk("run_done0", 32'(done), 32'h0);
        chk("run_a0", 32'(a), 32'h1);
        chk("run_b0", 32'(b), 32'h1);
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (n < 3000) begin
            @(posedge clock);
            n++;
            #1;
            if (done) break;
            if (n == repulse) start = 1'b1;
            if (n == repulse + 1) start = 1'b0;
            if (n == rst_at) begin
                #2;
                reset = 1'b1;
                #1;
                chk_zero("midrst");
                @(negedge clock);
                reset = 1'b0;
                n = -1;
                return;
            end
        end
        chk("run_timeout", 32'(n < 3000), 32'h1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mode     = 0;
        start    = 1'b0;
        reset    = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk_zero("reset");
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("idle_busy", 32'(busy), 32'h0);
        chk("idle_done", 32'(done), 32'h0);

        // good array from IDLE
        run(-10, -10, cyc);
        chk("good_cyc", 32'(cyc), 32'd1024);
        chk("good_pass", 32'(pass), 32'h1);
        chk("good_err", 32'(err_count), 32'd0);
        chk("good_fi", 32'(fail_i), 32'd0);
        chk("good_fj", 32'(fail_j), 32'd0);
        chk("good_a", 32'(a), 32'hFFFF);
        chk("good_b", 32'(b), 32'hFFFF);
        chk("good_busy", 32'(busy), 32'h0);

        // bit 5 stuck at 0, restarted from DONE
        mode = 1;
        run(-10, -10, cyc);
`ifdef BIST_STOP_ON_FAIL_EN
        chk("b5_cyc", 32'(cyc), 32'd344);
        chk("b5_err", 32'(err_count), 32'd1);
`else
        chk("b5_cyc", 32'(cyc), 32'd1024);
        chk("b5_err", 32'(err_count), 32'd121);
`endif
        chk("b5_pass", 32'(pass), 32'h0);
        chk("b5_fi", 32'(fail_i), 32'd5);
        chk("b5_fj", 32'(fail_j), 32'd5);

        // output tied high
        mode = 2;
        run(-10, -10, cyc);
`ifdef BIST_STOP_ON_FAIL_EN
        chk("ff_cyc", 32'(cyc), 32'd4);
        chk("ff_err", 32'(err_count), 32'd1);
`else
        chk("ff_cyc", 32'(cyc), 32'd1024);
        chk("ff_err", 32'(err_count), 32'd255);
`endif
        chk("ff_pass", 32'(pass), 32'h0);
        chk("ff_fi", 32'(fail_i), 32'd0);
        chk("ff_fj", 32'(fail_j), 32'd0);

        // reset mid-run
        mode = 0;
        run(-10, 100, cyc);
        chk("midrst_ret", 32'(cyc), 32'hFFFF_FFFF);
        repeat (2) @(posedge clock);
        #1;
        chk("midrst_idle_done", 32'(done), 32'h0);
        chk("midrst_idle_a", 32'(a), 32'h0);

        // start re-pulsed while busy is ignored
        run(50, -10, cyc);
        chk("rep_cyc", 32'(cyc), 32'd1024);
        chk("rep_pass", 32'(pass), 32'h1);
        chk("rep_err", 32'(err_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
